alarm_monitor_mc: RTL and testbench

Parametrised multi-channel successor to the two-sensor alarm monitor. It samples NUM_CH sensor channels and classifies them as HIGH, MID or LOW. A class must persist for a set number of cycles before it is committed. HIGH alarms are latched with an interrupt pulse and an acknowledge handshake, and a saturating power register tracks mode plus sensor activity. The block sits between the sensor front-end registers and the LED/interrupt controller.

---
 rtl/alarm_monitor_pkg.sv | 43 ++++
 rtl/alarm_persist_filter.sv | 42 ++++
 rtl/alarm_monitor_mc.sv | 119 +++++++++++
 tb/tb_alarm_monitor_mc.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alarm_monitor_pkg.sv
// Shared types and constants for the multi-channel alarm monitor.
package alarm_monitor_pkg;

  localparam int CLS_W = 2;

  // CLS_NONE is never produced by the classifier, so a reset candidate matches nothing.
  typedef enum logic [CLS_W-1:0] {
    CLS_NONE = 2'd0,
    CLS_LOW  = 2'd1,
    CLS_MID  = 2'd2,
    CLS_HIGH = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ALARM  = 2'd1,
    ST_ACKED  = 2'd2
  } state_e;

  localparam logic [2:0] LED_NONE = 3'b000;
  localparam logic [2:0] LED_MID  = 3'b001;
  localparam logic [2:0] LED_LOW  = 3'b010;
  localparam logic [2:0] LED_HIGH = 3'b100;

  function automatic logic [3:0] base_power(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4'd1;
      2'b01:   return 4'd8;
      2'b10:   return 4'd15;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [2:0] cls_leds(input cls_e c);
    case (c)
      CLS_LOW:  return LED_LOW;
      CLS_MID:  return LED_MID;
      CLS_HIGH: return LED_HIGH;
      default:  return LED_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_persist_filter.sv
// Debounces the raw class: a class commits once it has been seen on PERSIST consecutive edges.
module alarm_persist_filter #(
  parameter int PERSIST = 3,
  parameter int CLS_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CLS_W-1:0] raw,
  output logic [CLS_W-1:0] cls_commit,
  output logic             commit
);
  localparam int CNT_W = $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CLS_W-1:0] cand, committed;
  logic [CNT_W-1:0] cnt;

  // cls_commit is the committed class as seen after this edge, so the FSM reacts on the commit edge.
  always_comb begin
    if (raw != cand) commit = (CNT_ONE == CNT_MAX);
    else             commit = (cnt != CNT_MAX) && ((cnt + CNT_ONE) == CNT_MAX);
    cls_commit = commit ? raw : committed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= '0;
      cnt       <= '0;
      committed <= '0;
    end else begin
      if (raw != cand) begin
        cand <= raw;
        cnt  <= CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
      committed <= cls_commit;
    end
  end

endmodule

// File: rtl/alarm_monitor_mc.sv
// Multi-channel alarm monitor: classifier, persistence filter, alarm FSM and power level.
module alarm_monitor_mc
  import alarm_monitor_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 4,
  parameter int HI_THRESH = 12,
  parameter int LO_THRESH = 4,
  parameter int PERSIST   = 3,
  parameter int PWR_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] sensor,
  input  logic [1:0]               mode,
  input  logic                     ack,
  output logic [2:0]               alarm_leds,
  output logic [NUM_CH-1:0]        alarm_ch,
  output logic                     irq,
  output logic [PWR_W-1:0]         pwr_reg
);
  localparam int NBITS = NUM_CH * DATA_W;
  localparam int POP_W = $clog2(NBITS + 1);
  localparam int SUM_W = ((PWR_W > POP_W) ? PWR_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] PWR_MAX = SUM_W'({PWR_W{1'b1}});
  localparam logic [DATA_W:0]  HI_T    = (DATA_W + 1)'(HI_THRESH);
  localparam logic [DATA_W:0]  LO_T    = (DATA_W + 1)'(LO_THRESH);

  logic [NUM_CH-1:0] hi_bits, lo_bits;
  cls_e              raw_cls, cls_nxt;
  logic [CLS_W-1:0]  cls_commit;
  logic              commit;
  state_e            state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hi_bits[i] = {1'b0, sensor[i*DATA_W +: DATA_W]} > HI_T;
    assign lo_bits[i] = {1'b0, sensor[i*DATA_W +: DATA_W]} < LO_T;
  end

  always_comb begin
    if (|hi_bits)      raw_cls = CLS_HIGH;
    else if (&lo_bits) raw_cls = CLS_LOW;
    else               raw_cls = CLS_MID;
  end

  alarm_persist_filter #(.PERSIST(PERSIST), .CLS_W(CLS_W)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .raw        (raw_cls),
    .cls_commit (cls_commit),
    .commit     (commit)
  );

  assign cls_nxt = cls_e'(cls_commit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_NORMAL;
      alarm_leds <= LED_NONE;
      alarm_ch   <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        ST_NORMAL: begin
          if (commit && cls_nxt == CLS_HIGH) begin
            state      <= ST_ALARM;
            irq        <= 1'b1;
            alarm_leds <= LED_HIGH;
            alarm_ch   <= hi_bits;
          end else begin
            alarm_leds <= cls_leds(cls_nxt);
          end
        end
        ST_ALARM: begin
          alarm_ch <= alarm_ch | hi_bits;
          if (ack) begin
            if (cls_nxt != CLS_HIGH) begin
              state      <= ST_NORMAL;
              alarm_ch   <= '0;
              alarm_leds <= cls_leds(cls_nxt);
            end else begin
              state <= ST_ACKED;
            end
          end
        end
        ST_ACKED: begin
          alarm_ch <= alarm_ch | hi_bits;
          if (cls_nxt != CLS_HIGH) begin
            state      <= ST_NORMAL;
            alarm_ch   <= '0;
            alarm_leds <= cls_leds(cls_nxt);
          end
        end
        default: begin
          state      <= ST_NORMAL;
          alarm_leds <= LED_NONE;
          alarm_ch   <= '0;
        end
      endcase
    end
  end

  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] pwr_sum;

  always_comb begin
    pop = '0;
    for (int b = 0; b < NBITS; b++) pop = pop + POP_W'(sensor[b]);
    pwr_sum = SUM_W'(base_power(mode)) + SUM_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pwr_reg <= '0;
    else if (pwr_sum > PWR_MAX) pwr_reg <= {PWR_W{1'b1}};
    else                        pwr_reg <= pwr_sum[PWR_W-1:0];
  end

endmodule

// File: tb/tb_alarm_monitor_mc.sv
// Directed bench for alarm_monitor_mc: narrow default instance plus a wide one for power saturation.
module tb_alarm_monitor_mc;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sensor;
  logic [1:0] mode;
  logic       ack;
  logic [2:0] alarm_leds;
  logic [1:0] alarm_ch;
  logic       irq;
  logic [5:0] pwr_reg;

  logic [63:0] sensor_w;
  logic [1:0]  mode_w;
  logic [2:0]  leds_w;
  logic [7:0]  ch_w;
  logic        irq_w;
  logic [5:0]  pwr_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_monitor_mc dut (
    .clk(clk), .rst(rst), .sensor(sensor), .mode(mode), .ack(ack),
    .alarm_leds(alarm_leds), .alarm_ch(alarm_ch), .irq(irq), .pwr_reg(pwr_reg)
  );

  alarm_monitor_mc #(.NUM_CH(8), .DATA_W(8)) dut_w (
    .clk(clk), .rst(rst), .sensor(sensor_w), .mode(mode_w), .ack(1'b0),
    .alarm_leds(leds_w), .alarm_ch(ch_w), .irq(irq_w), .pwr_reg(pwr_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] glitch_vec [6];
  logic       glitch_irq [6];

  initial begin
    glitch_vec = '{{4'd13, 4'd5}, {4'd13, 4'd5}, {4'd5, 4'd5},
                   {4'd13, 4'd5}, {4'd13, 4'd5}, {4'd13, 4'd5}};
    glitch_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; sensor = '0; mode = 2'b00; ack = 1'b0; sensor_w = '0; mode_w = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_leds", alarm_leds, 3'b000);
    chk("rst_ch",   alarm_ch,   2'b00);
    chk("rst_irq",  irq,        1'b0);
    chk("rst_pwr",  pwr_reg,    6'd0);
    chk("rst_pwr_w", pwr_w,     6'd0);

    // Low class must persist three edges before the LEDs show it.
    @(negedge clk);
    rst = 1'b0; sensor = {4'd2, 4'd3};
    step(); chk("low_e1_leds", alarm_leds, 3'b000); chk("low_pwr", pwr_reg, 6'd4);
    step(); chk("low_e2_leds", alarm_leds, 3'b000);
    step(); chk("low_e3_leds", alarm_leds, 3'b010); chk("low_e3_irq", irq, 1'b0);

    sensor = {4'd13, 4'd3};
    step(); chk("hi_e1_irq", irq, 1'b0);
    step(); chk("hi_e2_irq", irq, 1'b0); chk("hi_e2_leds", alarm_leds, 3'b010);
    step(); chk("hi_e3_irq", irq, 1'b1); chk("hi_e3_leds", alarm_leds, 3'b100);
    chk("hi_e3_ch", alarm_ch, 2'b10); chk("hi_pwr", pwr_reg, 6'd6);

    sensor = {4'd13, 4'd14};
    step(); chk("acc_irq", irq, 1'b0); chk("acc_ch", alarm_ch, 2'b11);

    ack = 1'b1;
    step(); chk("ack_leds", alarm_leds, 3'b100); chk("ack_irq", irq, 1'b0); chk("ack_ch", alarm_ch, 2'b11);
    ack = 1'b0;

    // From ACKED, a MID commit leaves the alarm without any further ack.
    sensor = {4'd5, 4'd5}; mode = 2'b01;
    step(); chk("ackd_e1_leds", alarm_leds, 3'b100); chk("mid_pwr", pwr_reg, 6'd12);
    step(); chk("ackd_e2_leds", alarm_leds, 3'b100);
    step(); chk("ackd_e3_leds", alarm_leds, 3'b001); chk("ackd_e3_ch", alarm_ch, 2'b00);

    for (int i = 0; i < 6; i++) begin
      sensor = glitch_vec[i];
      step();
      chk($sformatf("glitch_irq%0d", i), irq, glitch_irq[i]);
      if (i == 2) chk("glitch_leds_mid", alarm_leds, 3'b001);
    end
    chk("glitch_leds", alarm_leds, 3'b100);
    chk("glitch_ch", alarm_ch, 2'b10);
    step(); chk("glitch_irq_hold", irq, 1'b0);

    // ack on the same edge as the HIGH->MID commit returns straight to NORMAL.
    sensor = {4'd5, 4'd5};
    step(); step(); chk("same_pre_leds", alarm_leds, 3'b100);
    ack = 1'b1;
    step(); chk("same_leds", alarm_leds, 3'b001); chk("same_ch", alarm_ch, 2'b00); chk("same_irq", irq, 1'b0);

    // ack held through NORMAL is ignored, then acted on the edge after alarm entry.
    sensor = {4'd13, 4'd5};
    step(); step(); chk("held_leds", alarm_leds, 3'b001);
    step(); chk("held_irq", irq, 1'b1); chk("held_alarm_leds", alarm_leds, 3'b100);
    step(); chk("held_irq2", irq, 1'b0); chk("held_acked_leds", alarm_leds, 3'b100);
    ack = 1'b0; sensor = {4'd5, 4'd5};
    step(); step(); chk("held_exit_pre", alarm_leds, 3'b100);
    step(); chk("held_exit_leds", alarm_leds, 3'b001); chk("held_exit_ch", alarm_ch, 2'b00);

    // Asynchronous reset while alarmed.
    sensor = {4'd13, 4'd5}; mode = 2'b11;
    step(); step(); step();
    chk("pre_rst_irq", irq, 1'b1); chk("mode3_pwr", pwr_reg, 6'd19);
    #2 rst = 1'b1;
    #1;
    chk("arst_leds", alarm_leds, 3'b000); chk("arst_ch", alarm_ch, 2'b00);
    chk("arst_irq", irq, 1'b0); chk("arst_pwr", pwr_reg, 6'd0);
    #1 rst = 1'b0;
    step(); chk("rea_e1_irq", irq, 1'b0); chk("rea_e1_leds", alarm_leds, 3'b000);
    step(); chk("rea_e2_irq", irq, 1'b0);
    step(); chk("rea_e3_irq", irq, 1'b1); chk("rea_e3_leds", alarm_leds, 3'b100); chk("rea_e3_ch", alarm_ch, 2'b10);

    // Wide instance: power level saturation and boundary.
    mode_w = 2'b10; sensor_w = {8{8'hFF}};
    step(); chk("wide_sat", pwr_w, 6'd63);
    mode_w = 2'b01; sensor_w = 64'h0000_0000_FFFF_FFFF;
    step(); chk("wide_40", pwr_w, 6'd40);
    mode_w = 2'b11; sensor_w = 64'h0001_FFFF_FFFF_FFFF;
    step(); chk("wide_63_exact", pwr_w, 6'd63);
    sensor_w = 64'h0000_FFFF_FFFF_FFFF;
    step(); chk("wide_62", pwr_w, 6'd62);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
